// File: rtl/watch_timekeeper.sv
// watch_timekeeper: seconds/minutes/hours counter for a digital watch.
// RUN advances on sec_tick; SET_H / SET_M step hours / minutes on a
// synchronised rising edge of the set button.
// Optional feature: define WATCH_SET_AUTOREPEAT_EN to auto-repeat the
// increment once per sec_tick after the button has been held for
// REPEAT_TICKS ticks in a set state.
module watch_timekeeper #(
  parameter int HOURS_MAX    = 24,
  parameter int REPEAT_TICKS = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sec_tick,
  input  logic [2:0] state,
  input  logic       inc,
  output logic [5:0] current_s,
  output logic [5:0] current_m,
  output logic [5:0] current_h,
  output logic       second
);

  localparam logic [2:0] ST_SET_H  = 3'b001;
  localparam logic [2:0] ST_SET_M  = 3'b010;
  localparam logic [5:0] HOUR_LAST = 6'(HOURS_MAX - 1);
  localparam logic [5:0] MS_LAST   = 6'd59;

  // Reject out-of-range configurations at elaboration time
  generate
    if (HOURS_MAX < 2 || HOURS_MAX > 63 || REPEAT_TICKS < 1 || REPEAT_TICKS > 15) begin : g_param_check
      $error("watch_timekeeper: HOURS_MAX or REPEAT_TICKS out of range");
    end
  endgenerate

  logic [5:0] r_s;
  logic [5:0] r_m;
  logic [5:0] r_h;
  logic       r_second;
  logic       r_inc_meta;
  logic       r_inc_sync;
  logic       r_inc_prev;

  logic w_set_h;
  logic w_set_m;
  logic w_in_set;
  logic w_inc_rise;
  logic w_rep_fire;
  logic w_step;
  logic w_s_wrap;
  logic w_m_wrap;
  logic w_h_wrap;

  assign w_set_h    = (state == ST_SET_H);
  assign w_set_m    = (state == ST_SET_M);
  assign w_in_set   = w_set_h | w_set_m;
  assign w_inc_rise = r_inc_sync & ~r_inc_prev;
  assign w_s_wrap   = (r_s == MS_LAST);
  assign w_m_wrap   = (r_m == MS_LAST);
  assign w_h_wrap   = (r_h == HOUR_LAST);

  // Two-flop synchroniser for the asynchronous button level plus edge register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_inc_meta <= 1'b0;
      r_inc_sync <= 1'b0;
      r_inc_prev <= 1'b0;
    end else begin
      r_inc_meta <= inc;
      r_inc_sync <= r_inc_meta;
      r_inc_prev <= r_inc_sync;
    end
  end

`ifdef WATCH_SET_AUTOREPEAT_EN
  localparam logic [3:0] REP_LIMIT = 4'(REPEAT_TICKS);

  logic [3:0] r_rep_cnt;

  // Once the hold count has saturated, every further tick is an extra step
  assign w_rep_fire = w_in_set & r_inc_sync & sec_tick & (r_rep_cnt == REP_LIMIT);

  // Count ticks while the button is held in a set state; saturate, clear on release
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rep_cnt <= 4'd0;
    end else if (!w_in_set || !r_inc_sync) begin
      r_rep_cnt <= 4'd0;
    end else if (sec_tick && (r_rep_cnt != REP_LIMIT)) begin
      r_rep_cnt <= r_rep_cnt + 4'd1;
    end
  end
`else
  assign w_rep_fire = 1'b0;
`endif

  // A button edge and an auto-repeat can never coincide (edge implies a cleared count)
  assign w_step = w_inc_rise | w_rep_fire;

  // Blink phase follows sec_tick regardless of mode
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_second <= 1'b0;
    end else if (sec_tick) begin
      r_second <= ~r_second;
    end
  end

  // Timekeeping: set modes hold seconds at zero and step one field without carry;
  // RUN advances on sec_tick with full carry chain
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s <= 6'd0;
      r_m <= 6'd0;
      r_h <= 6'd0;
    end else if (w_in_set) begin
      r_s <= 6'd0;
      if (w_set_h && w_step) begin
        r_h <= w_h_wrap ? 6'd0 : r_h + 6'd1;
      end
      if (w_set_m && w_step) begin
        r_m <= w_m_wrap ? 6'd0 : r_m + 6'd1;
      end
    end else if (sec_tick) begin
      if (w_s_wrap) begin
        r_s <= 6'd0;
        if (w_m_wrap) begin
          r_m <= 6'd0;
          r_h <= w_h_wrap ? 6'd0 : r_h + 6'd1;
        end else begin
          r_m <= r_m + 6'd1;
        end
      end else begin
        r_s <= r_s + 6'd1;
      end
    end
  end

  assign current_s = r_s;
  assign current_m = r_m;
  assign current_h = r_h;
  assign second    = r_second;

endmodule

// File: tb/tb_watch_timekeeper.sv
// Self-checking bench for watch_timekeeper: a default (24 h) instance and a
// 12 h instance share all stimulus; expected values come from a behavioural
// model of the watch and are queued when stimulus is applied.
module tb_watch_timekeeper;

  localparam logic [2:0] RUN   = 3'b000;
  localparam logic [2:0] SET_H = 3'b001;
  localparam logic [2:0] SET_M = 3'b010;

  logic       clk = 1'b0;
  logic       reset;
  logic       sec_tick;
  logic [2:0] state;
  logic       inc;
  logic [5:0] cur_s, cur_m, cur_h;
  logic       sec;
  logic [5:0] cur_s12, cur_m12, cur_h12;
  logic       sec12;

  int n_cmp = 0;
  int n_err = 0;

  // behavioural model of the 24 h watch plus the hour field of the 12 h watch
  int m_h, m_m, m_s, m_sec, m_h12;

  logic [24:0] exp_q[$];
  logic [24:0] got;
  logic [24:0] e;

  always #5 clk = ~clk;

  watch_timekeeper u_dut (
    .clk(clk), .reset(reset), .sec_tick(sec_tick), .state(state), .inc(inc),
    .current_s(cur_s), .current_m(cur_m), .current_h(cur_h), .second(sec)
  );

  watch_timekeeper #(.HOURS_MAX(12)) u_dut12 (
    .clk(clk), .reset(reset), .sec_tick(sec_tick), .state(state), .inc(inc),
    .current_s(cur_s12), .current_m(cur_m12), .current_h(cur_h12), .second(sec12)
  );

  function automatic logic is_set(input logic [2:0] st);
    return (st == SET_H) || (st == SET_M);
  endfunction

  function automatic logic [24:0] pack_exp(input int h, input int m, input int s,
                                           input int sc, input int h12);
    return {6'(h), 6'(m), 6'(s), 1'(sc), 6'(h12)};
  endfunction

  task automatic model_zero();
    m_h = 0; m_m = 0; m_s = 0; m_sec = 0; m_h12 = 0;
  endtask

  task automatic go_state(input logic [2:0] st);
    @(negedge clk);
    state = st;
    if (is_set(st)) m_s = 0;
    @(negedge clk);
  endtask

  task automatic do_tick();
    @(negedge clk);
    sec_tick = 1'b1;
    m_sec = m_sec ^ 1;
    if (!is_set(state)) begin
      if (m_s == 59) begin
        m_s = 0;
        if (m_m == 59) begin
          m_m = 0;
          m_h = (m_h + 1) % 24;
          m_h12 = (m_h12 + 1) % 12;
        end else begin
          m_m = m_m + 1;
        end
      end else begin
        m_s = m_s + 1;
      end
    end
    @(negedge clk);
    sec_tick = 1'b0;
  endtask

  task automatic do_inc();
    @(negedge clk);
    inc = 1'b1;
    repeat (3) @(negedge clk);
    inc = 1'b0;
    if (state == SET_H) begin
      m_h = (m_h + 1) % 24;
      m_h12 = (m_h12 + 1) % 12;
    end else if (state == SET_M) begin
      m_m = (m_m + 1) % 60;
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    // activity on every input while reset is held must not leak through
    sec_tick = 1'b1; inc = 1'b1; state = SET_H;
    repeat (4) @(negedge clk);
    exp_q.push_back(pack_exp(0, 0, 0, 0, 0));
    got = {cur_h, cur_m, cur_s, sec, cur_h12};
    e = exp_q.pop_front();
    n_cmp++;
    if (got !== e) begin
      n_err++;
      $display("FAIL reset_hold: got %0d:%0d:%0d sec=%0d h12=%0d want %0d:%0d:%0d sec=%0d h12=%0d",
               got[24:19], got[18:13], got[12:7], got[6], got[5:0], e[24:19], e[18:13], e[12:7], e[6], e[5:0]);
    end
    sec_tick = 1'b0; inc = 1'b0; state = RUN;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    exp_q.push_back(pack_exp(0, 0, 0, 0, 0));
    got = {cur_h, cur_m, cur_s, sec, cur_h12};
    e = exp_q.pop_front();
    n_cmp++;
    if (got !== e) begin
      n_err++;
      $display("FAIL reset_release_idle: got %0d:%0d:%0d sec=%0d h12=%0d want %0d:%0d:%0d sec=%0d h12=%0d",
               got[24:19], got[18:13], got[12:7], got[6], got[5:0], e[24:19], e[18:13], e[12:7], e[6], e[5:0]);
    end
    $display("txn reset: outputs %0d:%0d:%0d sec=%0d", cur_h, cur_m, cur_s, sec);
  endtask

  task automatic test_count_3661();
    for (int i = 0; i < 3661; i++) do_tick();
    exp_q.push_back(pack_exp(1, 1, 1, 1, 1));
    got = {cur_h, cur_m, cur_s, sec, cur_h12};
    e = exp_q.pop_front();
    n_cmp++;
    if (got !== e) begin
      n_err++;
      $display("FAIL count_3661: got %0d:%0d:%0d sec=%0d h12=%0d want %0d:%0d:%0d sec=%0d h12=%0d",
               got[24:19], got[18:13], got[12:7], got[6], got[5:0], e[24:19], e[18:13], e[12:7], e[6], e[5:0]);
    end
    $display("txn count_3661: %0d:%0d:%0d sec=%0d", cur_h, cur_m, cur_s, sec);
  endtask

  task automatic test_rollover();
    go_state(SET_H);
    exp_q.push_back(pack_exp(1, 1, 0, m_sec, 1));
    got = {cur_h, cur_m, cur_s, sec, cur_h12};
    e = exp_q.pop_front();
    n_cmp++;
    if (got !== e) begin
      n_err++;
      $display("FAIL set_entry_clears_s: got %0d:%0d:%0d sec=%0d h12=%0d want %0d:%0d:%0d sec=%0d h12=%0d",
               got[24:19], got[18:13], got[12:7], got[6], got[5:0], e[24:19], e[18:13], e[12:7], e[6], e[5:0]);
    end
    while (m_h != 23) do_inc();
    go_state(SET_M);
    while (m_m != 59) do_inc();
    go_state(RUN);
    while (m_s != 59) do_tick();
    // 22 hour steps from 1 on the 12 h watch land on 11
    exp_q.push_back(pack_exp(23, 59, 59, m_sec, 11));
    got = {cur_h, cur_m, cur_s, sec, cur_h12};
    e = exp_q.pop_front();
    n_cmp++;
    if (got !== e) begin
      n_err++;
      $display("FAIL preload_235959: got %0d:%0d:%0d sec=%0d h12=%0d want %0d:%0d:%0d sec=%0d h12=%0d",
               got[24:19], got[18:13], got[12:7], got[6], got[5:0], e[24:19], e[18:13], e[12:7], e[6], e[5:0]);
    end
    do_tick();
    exp_q.push_back(pack_exp(0, 0, 0, m_sec, 0));
    got = {cur_h, cur_m, cur_s, sec, cur_h12};
    e = exp_q.pop_front();
    n_cmp++;
    if (got !== e) begin
      n_err++;
      $display("FAIL day_rollover: got %0d:%0d:%0d sec=%0d h12=%0d want %0d:%0d:%0d sec=%0d h12=%0d",
               got[24:19], got[18:13], got[12:7], got[6], got[5:0], e[24:19], e[18:13], e[12:7], e[6], e[5:0]);
    end
    $display("txn rollover: %0d:%0d:%0d h12=%0d", cur_h, cur_m, cur_s, cur_h12);
  endtask

  task automatic test_set_hours();
    go_state(SET_H);
    while (m_h != 10) do_inc();
    go_state(SET_M);
    while (m_m != 20) do_inc();
    go_state(RUN);
    while (m_s != 35) do_tick();
    exp_q.push_back(pack_exp(10, 20, 35, m_sec, m_h12));
    got = {cur_h, cur_m, cur_s, sec, cur_h12};
    e = exp_q.pop_front();
    n_cmp++;
    if (got !== e) begin
      n_err++;
      $display("FAIL reach_102035: got %0d:%0d:%0d sec=%0d h12=%0d want %0d:%0d:%0d sec=%0d h12=%0d",
               got[24:19], got[18:13], got[12:7], got[6], got[5:0], e[24:19], e[18:13], e[12:7], e[6], e[5:0]);
    end
    go_state(SET_H);
    for (int i = 0; i < 3; i++) do_inc();
    exp_q.push_back(pack_exp(13, 20, 0, m_sec, m_h12));
    got = {cur_h, cur_m, cur_s, sec, cur_h12};
    e = exp_q.pop_front();
    n_cmp++;
    if (got !== e) begin
      n_err++;
      $display("FAIL set_h_3inc: got %0d:%0d:%0d sec=%0d h12=%0d want %0d:%0d:%0d sec=%0d h12=%0d",
               got[24:19], got[18:13], got[12:7], got[6], got[5:0], e[24:19], e[18:13], e[12:7], e[6], e[5:0]);
    end
    for (int i = 0; i < 15; i++) do_tick();
    exp_q.push_back(pack_exp(13, 20, 0, m_sec, m_h12));
    got = {cur_h, cur_m, cur_s, sec, cur_h12};
    e = exp_q.pop_front();
    n_cmp++;
    if (got !== e) begin
      n_err++;
      $display("FAIL set_h_ticks_frozen: got %0d:%0d:%0d sec=%0d h12=%0d want %0d:%0d:%0d sec=%0d h12=%0d",
               got[24:19], got[18:13], got[12:7], got[6], got[5:0], e[24:19], e[18:13], e[12:7], e[6], e[5:0]);
    end
    go_state(RUN);
    exp_q.push_back(pack_exp(13, 20, 0, m_sec, m_h12));
    got = {cur_h, cur_m, cur_s, sec, cur_h12};
    e = exp_q.pop_front();
    n_cmp++;
    if (got !== e) begin
      n_err++;
      $display("FAIL leave_set_keeps_hm: got %0d:%0d:%0d sec=%0d h12=%0d want %0d:%0d:%0d sec=%0d h12=%0d",
               got[24:19], got[18:13], got[12:7], got[6], got[5:0], e[24:19], e[18:13], e[12:7], e[6], e[5:0]);
    end
    $display("txn set_hours: %0d:%0d:%0d", cur_h, cur_m, cur_s);
  endtask

  task automatic test_set_minutes();
    go_state(SET_H);
    while (m_h != 5) do_inc();
    go_state(SET_M);
    while (m_m != 59) do_inc();
    do_inc();
    exp_q.push_back(pack_exp(5, 0, 0, m_sec, m_h12));
    got = {cur_h, cur_m, cur_s, sec, cur_h12};
    e = exp_q.pop_front();
    n_cmp++;
    if (got !== e) begin
      n_err++;
      $display("FAIL set_m_wrap_no_carry: got %0d:%0d:%0d sec=%0d h12=%0d want %0d:%0d:%0d sec=%0d h12=%0d",
               got[24:19], got[18:13], got[12:7], got[6], got[5:0], e[24:19], e[18:13], e[12:7], e[6], e[5:0]);
    end
    // place sec_tick on the same edge that sees the synchronised rising edge
    @(negedge clk);
    inc = 1'b1;
    @(negedge clk);
    @(negedge clk);
    sec_tick = 1'b1;
    @(negedge clk);
    sec_tick = 1'b0;
    inc = 1'b0;
    m_m = m_m + 1;
    m_sec = m_sec ^ 1;
    repeat (3) @(negedge clk);
    exp_q.push_back(pack_exp(5, 1, 0, m_sec, m_h12));
    got = {cur_h, cur_m, cur_s, sec, cur_h12};
    e = exp_q.pop_front();
    n_cmp++;
    if (got !== e) begin
      n_err++;
      $display("FAIL inc_with_tick: got %0d:%0d:%0d sec=%0d h12=%0d want %0d:%0d:%0d sec=%0d h12=%0d",
               got[24:19], got[18:13], got[12:7], got[6], got[5:0], e[24:19], e[18:13], e[12:7], e[6], e[5:0]);
    end
    $display("txn set_minutes: %0d:%0d:%0d", cur_h, cur_m, cur_s);
  endtask

  task automatic test_run_ignores_inc();
    go_state(RUN);
    do_inc();
    do_inc();
    exp_q.push_back(pack_exp(5, 1, 0, m_sec, m_h12));
    got = {cur_h, cur_m, cur_s, sec, cur_h12};
    e = exp_q.pop_front();
    n_cmp++;
    if (got !== e) begin
      n_err++;
      $display("FAIL run_ignores_inc: got %0d:%0d:%0d sec=%0d h12=%0d want %0d:%0d:%0d sec=%0d h12=%0d",
               got[24:19], got[18:13], got[12:7], got[6], got[5:0], e[24:19], e[18:13], e[12:7], e[6], e[5:0]);
    end
    $display("txn run_inc: %0d:%0d:%0d", cur_h, cur_m, cur_s);
  endtask

  task automatic test_autorepeat();
    go_state(SET_M);
    while (m_m != 0) do_inc();
    @(negedge clk);
    inc = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 5; i++) do_tick();
    inc = 1'b0;
    repeat (3) @(negedge clk);
`ifdef WATCH_SET_AUTOREPEAT_EN
    m_m = 4;
`else
    m_m = 1;
`endif
    exp_q.push_back(pack_exp(5, m_m, 0, m_sec, m_h12));
    got = {cur_h, cur_m, cur_s, sec, cur_h12};
    e = exp_q.pop_front();
    n_cmp++;
    if (got !== e) begin
      n_err++;
      $display("FAIL held_inc_5_ticks: got %0d:%0d:%0d sec=%0d h12=%0d want %0d:%0d:%0d sec=%0d h12=%0d",
               got[24:19], got[18:13], got[12:7], got[6], got[5:0], e[24:19], e[18:13], e[12:7], e[6], e[5:0]);
    end
    $display("txn autorepeat: minutes=%0d", cur_m);
  endtask

  task automatic test_async_reset();
    go_state(SET_H);
    while (m_h != 12) do_inc();
    go_state(SET_M);
    while (m_m != 34) do_inc();
    go_state(RUN);
    while (m_s != 56) do_tick();
    exp_q.push_back(pack_exp(12, 34, 56, m_sec, m_h12));
    got = {cur_h, cur_m, cur_s, sec, cur_h12};
    e = exp_q.pop_front();
    n_cmp++;
    if (got !== e) begin
      n_err++;
      $display("FAIL reach_123456: got %0d:%0d:%0d sec=%0d h12=%0d want %0d:%0d:%0d sec=%0d h12=%0d",
               got[24:19], got[18:13], got[12:7], got[6], got[5:0], e[24:19], e[18:13], e[12:7], e[6], e[5:0]);
    end
    // assert reset between edges and look before the next rising edge
    @(posedge clk);
    #2;
    reset = 1'b1;
    model_zero();
    #1;
    exp_q.push_back(pack_exp(0, 0, 0, 0, 0));
    got = {cur_h, cur_m, cur_s, sec, cur_h12};
    e = exp_q.pop_front();
    n_cmp++;
    if (got !== e) begin
      n_err++;
      $display("FAIL async_reset: got %0d:%0d:%0d sec=%0d h12=%0d want %0d:%0d:%0d sec=%0d h12=%0d",
               got[24:19], got[18:13], got[12:7], got[6], got[5:0], e[24:19], e[18:13], e[12:7], e[6], e[5:0]);
    end
    // tick on the very first edge after release is honoured
    @(negedge clk);
    reset = 1'b0;
    sec_tick = 1'b1;
    m_s = 1;
    m_sec = 1;
    @(negedge clk);
    sec_tick = 1'b0;
    exp_q.push_back(pack_exp(0, 0, 1, 1, 0));
    got = {cur_h, cur_m, cur_s, sec, cur_h12};
    e = exp_q.pop_front();
    n_cmp++;
    if (got !== e) begin
      n_err++;
      $display("FAIL tick_at_release: got %0d:%0d:%0d sec=%0d h12=%0d want %0d:%0d:%0d sec=%0d h12=%0d",
               got[24:19], got[18:13], got[12:7], got[6], got[5:0], e[24:19], e[18:13], e[12:7], e[6], e[5:0]);
    end
    $display("txn async_reset: %0d:%0d:%0d sec=%0d", cur_h, cur_m, cur_s, sec);
  endtask

  initial begin
    reset = 1'b1;
    sec_tick = 1'b0;
    inc = 1'b0;
    state = RUN;
    model_zero();
    test_reset();
    test_count_3661();
    test_rollover();
    test_set_hours();
    test_set_minutes();
    test_run_ignores_inc();
    test_autorepeat();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

endmodule

// File: doc/watch_timekeeper.md
WATCH_TIMEKEEPER -- requirements
Module: watch_timekeeper

Interface
REQ-001 SHALL provide parameter HOURS_MAX, default 24, meaning the hour modulus; legal range 2..63.
REQ-002 SHALL provide parameter REPEAT_TICKS, default 2, meaning the sec_tick count of held inc before auto-repeat; legal range 1..15.
REQ-003 SHALL have port clk, input, 1 bit: the single system clock; all state is on posedge clk.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port sec_tick, input, 1 bit: synchronous one-clk-wide pulse, once per second.
REQ-006 SHALL have port state, input, 3 bits: watch mode from the watch FSM; 3'b001 = SET_H, 3'b010 = SET_M, all other codes = RUN.
REQ-007 SHALL have port inc, input, 1 bit: asynchronous level from the set button, already debounced.
REQ-008 SHALL have port current_s, output, 6 bits: seconds, binary 0..59.
REQ-009 SHALL have port current_m, output, 6 bits: minutes, binary 0..59.
REQ-010 SHALL have port current_h, output, 6 bits: hours, binary 0..HOURS_MAX-1.
REQ-011 SHALL have port second, output, 1 bit: blink phase for the display stage.

Function
REQ-012 SHALL register all outputs; no combinational path from any input to any output.
REQ-013 In RUN, sec_tick=1 SHALL advance the time one second at that clk edge, visible the following cycle.
REQ-014 Seconds 59 plus a tick SHALL go to 0 and carry to minutes; minutes 59 plus a carry SHALL go to 0 and carry to hours; hours HOURS_MAX-1 plus a carry SHALL go to 0. Example: 23:59:59 -> 00:00:00.
REQ-015 inc SHALL pass through a 2-flop synchroniser and a rising-edge detector; an inc rising edge SHALL update the time at the 3rd clk edge after inc is first sampled high.
REQ-016 In SET_H, an inc edge SHALL set current_h to (current_h+1) mod HOURS_MAX, with no carry and no change to current_m.
REQ-017 In SET_M, an inc edge SHALL set current_m to (current_m+1) mod 60, with no carry to hours.
REQ-018 In SET_H or SET_M, sec_tick SHALL NOT advance the time, and current_s SHALL be held at 0.
REQ-019 On the clk edge where state enters SET_H or SET_M from RUN, current_s SHALL clear to 0.
REQ-020 In RUN, inc edges SHALL be ignored.
REQ-021 If sec_tick and an inc edge coincide in a set state, only the increment SHALL apply.
REQ-022 second SHALL toggle on every sec_tick in all states.
REQ-023 A change of state with no set-to-set transition SHALL NOT alter current_m or current_h.

Reset
REQ-024 While reset=1, current_s, current_m, current_h, second, the synchroniser flops, the edge register and the repeat counter SHALL all be 0, independent of clk.
REQ-025 Reset asserted mid-carry or mid-increment SHALL leave no partial update; the first operation after deassertion SHALL start from 00:00:00.
REQ-026 Deassertion SHALL take effect at the first clk edge with reset=0; a sec_tick at that edge SHALL be honoured.

Configuration
REQ-027 With macro WATCH_SET_AUTOREPEAT_EN defined, holding the synchronised inc high in a set state for REPEAT_TICKS sec_ticks SHALL produce one extra increment per subsequent sec_tick until inc falls or state leaves the set states; the repeat counter SHALL saturate and clear on inc low.
REQ-028 Without WATCH_SET_AUTOREPEAT_EN, only rising edges SHALL increment; the repeat counter logic SHALL be absent.

Verification
REQ-029 Reset, then state=RUN and 3661 sec_ticks -> 01:01:01 and second=1.
REQ-030 Preload 23:59:59 in RUN, then 1 sec_tick -> 00:00:00 on the next cycle. With HOURS_MAX=12, 11:59:59 -> 00:00:00.
REQ-031 state=SET_H at 10:20:35, then 3 inc pulses -> 13:20:00; 15 sec_ticks -> time unchanged.
REQ-032 SET_M at 05:59:xx, then 1 inc -> 05:00:00 (no hour carry). An inc edge coincident with sec_tick -> exactly +1 minute.
REQ-033 Assert reset asynchronously between clk edges at 12:34:56 -> all outputs 0 before the next edge.
REQ-034 With WATCH_SET_AUTOREPEAT_EN and REPEAT_TICKS=2, SET_M from 00, inc held for 5 sec_ticks -> minutes 4. Without the macro -> minutes 1.
